// File: rtl/key_run_length_recorder.sv
// Records the music-key vector as {keys, duration} runs and replays them tick-for-tick.
// Build option: KEY_RECORDER_LOOP_PLAYBACK_EN makes playback wrap to entry 0 instead of ending.
module key_run_length_recorder #(
  parameter int DEPTH     = 256,
  parameter int ADDR_W    = 8,
  parameter int DUR_W     = 10,
  parameter int MAX_TICKS = 3000
) (
  input  logic              CLK_100hz,
  input  logic              systemReset_n,
  input  logic              record_req,
  input  logic              play_req,
  input  logic [5:0]        keys_in_n,
  output logic [5:0]        keys_out,
  output logic              busy_record,
  output logic              busy_play,
  output logic              play_done,
  output logic              overflow,
  output logic [ADDR_W:0]   entry_count
);

  localparam int TICK_W = $clog2(MAX_TICKS);
  localparam int ENT_W  = 6 + DUR_W;
  localparam logic [DUR_W-1:0]  DUR_MAX   = '1;
  localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(MAX_TICKS - 1);

  typedef enum logic [1:0] {IDLE, RECORD, FLUSH, PLAY} state_t;

  logic       rec_s1_q, rec_s2_q, rec_prev_q;
  logic       play_s1_q, play_s2_q, play_prev_q;
  logic [5:0] keys_s1_q, keys_s2_q;
  logic       rec_edge, play_edge;
  logic [5:0] cur_keys;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     wr_ptr_q, wr_ptr_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [5:0]          run_keys_q, run_keys_d;
  logic [DUR_W-1:0]    run_len_q, run_len_d;
  logic                overflow_q, overflow_d;
  logic [ADDR_W:0]     entry_count_q, entry_count_d;
  logic [ADDR_W:0]     rd_ptr_q, rd_ptr_d;
  logic                next_valid_q, next_valid_d;
  logic                prime_q, prime_d;
  logic [DUR_W-1:0]    dur_cnt_q, dur_cnt_d;
  logic [5:0]          keys_out_q, keys_out_d;
  logic                play_done_q, play_done_d;

  logic                mem_we;
  logic                fetch;
  logic [ENT_W-1:0]    mem [0:(1<<ADDR_W)-1];
  logic [ENT_W-1:0]    rd_data_q;

  always_ff @(posedge CLK_100hz or negedge systemReset_n) begin
    if (!systemReset_n) begin
      rec_s1_q    <= 1'b0;
      rec_s2_q    <= 1'b0;
      rec_prev_q  <= 1'b0;
      play_s1_q   <= 1'b0;
      play_s2_q   <= 1'b0;
      play_prev_q <= 1'b0;
      keys_s1_q   <= '1;
      keys_s2_q   <= '1;
    end else begin
      rec_s1_q    <= record_req;
      rec_s2_q    <= rec_s1_q;
      rec_prev_q  <= rec_s2_q;
      play_s1_q   <= play_req;
      play_s2_q   <= play_s1_q;
      play_prev_q <= play_s2_q;
      keys_s1_q   <= keys_in_n;
      keys_s2_q   <= keys_s1_q;
    end
  end

  assign rec_edge  = rec_s2_q & ~rec_prev_q;
  assign play_edge = play_s2_q & ~play_prev_q;
  assign cur_keys  = ~keys_s2_q;

  // rd_data_q only advances on a fetch so it can hold the prefetched next entry.
  always_ff @(posedge CLK_100hz) begin
    if (mem_we) mem[wr_ptr_q[ADDR_W-1:0]] <= {run_keys_q, run_len_q};
    if (fetch)  rd_data_q <= mem[rd_ptr_q[ADDR_W-1:0]];
  end

  always_ff @(posedge CLK_100hz or negedge systemReset_n) begin
    if (!systemReset_n) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      tick_cnt_q    <= '0;
      run_keys_q    <= '0;
      run_len_q     <= '0;
      overflow_q    <= 1'b0;
      entry_count_q <= '0;
      rd_ptr_q      <= '0;
      next_valid_q  <= 1'b0;
      prime_q       <= 1'b0;
      dur_cnt_q     <= '0;
      keys_out_q    <= '0;
      play_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      tick_cnt_q    <= tick_cnt_d;
      run_keys_q    <= run_keys_d;
      run_len_q     <= run_len_d;
      overflow_q    <= overflow_d;
      entry_count_q <= entry_count_d;
      rd_ptr_q      <= rd_ptr_d;
      next_valid_q  <= next_valid_d;
      prime_q       <= prime_d;
      dur_cnt_q     <= dur_cnt_d;
      keys_out_q    <= keys_out_d;
      play_done_q   <= play_done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    tick_cnt_d    = tick_cnt_q;
    run_keys_d    = run_keys_q;
    run_len_d     = run_len_q;
    overflow_d    = overflow_q;
    entry_count_d = entry_count_q;
    rd_ptr_d      = rd_ptr_q;
    next_valid_d  = next_valid_q;
    prime_d       = prime_q;
    dur_cnt_d     = dur_cnt_q;
    keys_out_d    = keys_out_q;
    play_done_d   = 1'b0;
    mem_we        = 1'b0;
    fetch         = 1'b0;

    case (state_q)
      IDLE: begin
        if (rec_edge) begin
          state_d    = RECORD;
          wr_ptr_d   = '0;
          tick_cnt_d = '0;
          run_len_d  = '0;
          overflow_d = 1'b0;
        end else if (play_edge) begin
          if (entry_count_q != '0) begin
            state_d      = PLAY;
            rd_ptr_d     = '0;
            prime_d      = 1'b1;
            next_valid_d = 1'b0;
            dur_cnt_d    = '0;
          end else begin
            play_done_d = 1'b1;
          end
        end
      end

      RECORD: begin
        // The stop-edge tick itself is not sampled.
        if (rec_edge) begin
          state_d = FLUSH;
        end else begin
          tick_cnt_d = tick_cnt_q + 1'b1;
          if (run_len_q == '0) begin
            run_keys_d = cur_keys;
            run_len_d  = DUR_W'(1);
          end else if ((cur_keys != run_keys_q) || (run_len_q == DUR_MAX)) begin
            if (wr_ptr_q == DEPTH_C) begin
              overflow_d = 1'b1;
              run_len_d  = '0;
              state_d    = FLUSH;
            end else begin
              mem_we     = 1'b1;
              wr_ptr_d   = wr_ptr_q + 1'b1;
              run_keys_d = cur_keys;
              run_len_d  = DUR_W'(1);
            end
          end else begin
            run_len_d = run_len_q + 1'b1;
          end
          if (tick_cnt_q == TICK_LAST) state_d = FLUSH;
        end
      end

      FLUSH: begin
        if ((run_len_q != '0) && (wr_ptr_q < DEPTH_C)) begin
          mem_we        = 1'b1;
          entry_count_d = wr_ptr_q + 1'b1;
        end else begin
          entry_count_d = wr_ptr_q;
        end
        run_len_d = '0;
        state_d   = IDLE;
      end

      PLAY: begin
        if (play_edge) begin
          state_d     = IDLE;
          keys_out_d  = '0;
          play_done_d = 1'b1;
        end else if (prime_q) begin
          prime_d = 1'b0;
          fetch   = 1'b1;
        end else if (dur_cnt_q <= DUR_W'(1)) begin
          if (next_valid_q) begin
            keys_out_d = rd_data_q[ENT_W-1 -: 6];
            dur_cnt_d  = rd_data_q[DUR_W-1:0];
            fetch      = 1'b1;
          end else begin
            state_d     = IDLE;
            keys_out_d  = '0;
            play_done_d = 1'b1;
          end
        end else begin
          dur_cnt_d = dur_cnt_q - 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    if (fetch) begin
`ifdef KEY_RECORDER_LOOP_PLAYBACK_EN
      next_valid_d = 1'b1;
      rd_ptr_d     = (rd_ptr_q == entry_count_q - 1'b1) ? '0 : rd_ptr_q + 1'b1;
`else
      next_valid_d = (rd_ptr_q < entry_count_q);
      rd_ptr_d     = rd_ptr_q + 1'b1;
`endif
    end
  end

  assign keys_out    = keys_out_q;
  assign busy_record = (state_q == RECORD) || (state_q == FLUSH);
  assign busy_play   = (state_q == PLAY);
  assign play_done   = play_done_q;
  assign overflow    = overflow_q;
  assign entry_count = entry_count_q;

endmodule

// File: doc/key_run_length_recorder.md
Name: key_run_length_recorder

Overview:
- Records the smoothed music-key vector as run-length entries {keys, duration} in an internal RAM while a recording is active.
- Reads the entries back on request and reproduces the key vector tick-for-tick, so the tone generator can replay a user recording.
- Sits between the UI smoothers / state controller and the frequency generator.
- Runs entirely on the 100 Hz tick (10 ms resolution).

Parameters:
- DEPTH, 256: number of run entries in RAM.
- ADDR_W, 8: address width; must satisfy 2^ADDR_W >= DEPTH.
- DUR_W, 10: run-length counter width; maximum run is 1023 ticks.
- MAX_TICKS, 3000: recording time limit in ticks (30 s).

Ports:
- CLK_100hz  in  1  block clock.
- systemReset_n  in  1  reset.
- record_req  in  1  active-high level from the 50 MHz domain; rising edge toggles recording start/stop.
- play_req  in  1  active-high level from the 50 MHz domain; rising edge starts playback or aborts it.
- keys_in_n  in  6  smoothed music keys, active-low.
- keys_out  out  6  playback key vector, active-high.
- busy_record  out  1  high while recording.
- busy_play  out  1  high while playing.
- play_done  out  1  one-cycle pulse when playback ends or is aborted.
- overflow  out  1  sticky; set when the RAM filled during the last recording.
- entry_count  out  ADDR_W+1  number of valid entries stored.

Interface: reset systemReset_n, asynchronous, active-low; clock CLK_100hz.

Behaviour:
- Reset values: all outputs 0, state IDLE. RAM contents are undefined after reset; entry_count=0 marks the RAM empty.
- Synchronisers:
  - keys_in_n, record_req and play_req each pass through a 2-FF synchroniser.
  - The request lines are then rising-edge detected.
  - An edge is visible 3 ticks after the input rises.
- States: IDLE, RECORD, FLUSH, PLAY.
- IDLE:
  - Record edge -> RECORD. Clear wr_ptr, tick_cnt, run_len and overflow.
  - Play edge -> PLAY if entry_count>0. If entry_count=0, pulse play_done and stay in IDLE.
  - Simultaneous record and play edges: record wins.
- RECORD, each tick, with cur = ~keys_sync:
  - First tick: run_keys=cur, run_len=1.
  - If cur!=run_keys or run_len==2^DUR_W-1: write {run_keys,run_len} to mem[wr_ptr], increment wr_ptr, then run_keys=cur, run_len=1.
  - Otherwise: increment run_len.
  - tick_cnt increments every tick.
- RECORD exits to FLUSH on any of:
  - a record edge;
  - tick_cnt==MAX_TICKS-1;
  - wr_ptr==DEPTH with a write pending. In this case set overflow and discard the pending run.
  - Play edges are ignored in RECORD.
- FLUSH (1 tick):
  - Write the pending run if run_len>0 and wr_ptr<DEPTH.
  - entry_count <= final wr_ptr.
  - Go to IDLE.
- PLAY:
  - The RAM is synchronous (1-tick read latency).
  - The next entry is prefetched while the current one runs, so there is no gap tick between entries.
  - keys_out first becomes entry 0's keys 2 ticks after the play edge is detected.
  - Each entry's keys are held for exactly dur ticks.
  - After the last entry, keys_out=0, play_done pulses for 1 tick, state returns to IDLE.
  - A play edge during PLAY aborts playback: keys_out=0 on the next tick, play_done pulses, state returns to IDLE.
  - Record edges are ignored in PLAY.
- busy_record is high in RECORD and FLUSH. busy_play is high in PLAY.
- Asynchronous reset mid-operation: everything returns to reset values. The recording is lost (entry_count=0).
- A new recording always overwrites from address 0.

Optional Feature:
- Macro: KEY_RECORDER_LOOP_PLAYBACK_EN.
- Defined: at the end of the last entry, playback wraps seamlessly to entry 0 with no gap tick. play_done does not pulse on wrap. It pulses only on abort by a play edge.
- Undefined: one-shot playback as described under Behaviour.

Test Plan:
- Record 0 ticks: record edge, record edge again immediately -> entry_count=0. A following play edge -> play_done pulse, keys_out stays 0.
- Hold keys_in_n=6'b111110 for 50 ticks, then 6'b111101 for 20 ticks, then stop -> entry_count=2, entries {000001,50} and {000010,20}.
- Play that recording -> keys_out=000001 for exactly 50 ticks, then 000010 for exactly 20 ticks, then 0; play_done pulses on the following tick.
- Hold one key for 1500 ticks -> run splits into {k,1023} and {k,477}. The recording auto-stops at tick 3000 with tick_cnt limit reached and overflow=0.
- Toggle a key every tick with DEPTH=4 -> overflow=1, entry_count=4, busy_record falls without any record edge.
- Play edge 100 ticks into playback -> keys_out=0 and play_done pulse within 4 ticks. Asserting reset mid-record -> entry_count=0 and all outputs 0 immediately.
